// File: rtl/adc_channel_scheduler.sv
// Round-robin channel sequencer for the LTC2308 interface: tags one-frame-late results with their channel.
// Optional per-channel block averaging is compiled in with `define ADC_SCHED_AVG_EN.
module adc_channel_scheduler #(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [2:0]        adc_chan,
    input  logic [11:0]       adc_result,
    input  logic              adc_valid,
    output logic              smp_valid,
    output logic [2:0]        smp_chan,
    output logic [11:0]       smp_data,
    input  logic [2:0]        rd_chan,
    input  logic              rd_en,
    output logic [11:0]       rd_data,
    output logic [NUM_CH-1:0] ch_fresh,
    output logic [NUM_CH-1:0] ch_ovr,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              stop_req, start, advance, take, pub;
    logic [2:0]        pending;
    logic [11:0]       pub_data;
    logic [11:0]       regs [NUM_CH];
    logic [NUM_CH-1:0] set_v, clr_v;
    logic              rd_ok;

    function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = 3'(i);
        end
    endfunction

    // First set bit strictly after c with wrap; c itself is reached last, so a lone bit returns c.
    function automatic logic [2:0] next_ch(input logic [2:0] c, input logic [NUM_CH-1:0] m);
        int   idx;
        logic found;
        next_ch = c;
        found   = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(c) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && m[idx]) begin
                next_ch = 3'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    assign stop_req = !enable || (ch_mask == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!stop_req) state_nxt = PRIME;
            PRIME:   if (adc_valid) state_nxt = RUN;
                     else if (stop_req) state_nxt = IDLE;
            RUN:     if (stop_req) state_nxt = DRAIN;
            DRAIN:   if (adc_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start   = (state == IDLE) && !stop_req;
        advance = adc_valid && ((state == PRIME) || (state == RUN));
        take    = adc_valid && ((state == RUN) || (state == DRAIN));
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_chan <= 3'd0;
            pending  <= 3'd0;
        end else if (start) begin
            adc_chan <= lowest_ch(ch_mask);
        end else if (advance) begin
            pending  <= adc_chan;
            adc_chan <= next_ch(adc_chan, ch_mask);
        end
    end

`ifdef ADC_SCHED_AVG_EN
    logic [11+AVG_LOG2:0] acc [NUM_CH];
    logic [AVG_LOG2-1:0]  cnt [NUM_CH];
    logic [11+AVG_LOG2:0] sum;

    function automatic logic [11:0] avg_trunc(input logic [11+AVG_LOG2:0] s);
        avg_trunc = 12'(s >> AVG_LOG2);
    endfunction

    always_comb begin
        sum      = acc[pending] + (12 + AVG_LOG2)'(adc_result);
        pub      = take && (cnt[pending] == {AVG_LOG2{1'b1}});
        pub_data = avg_trunc(sum);
    end

    // A drain result that does not complete its block is dropped along with the partial sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (take) begin
            if (pub || (state == DRAIN)) begin
                acc[pending] <= '0;
                cnt[pending] <= '0;
            end else begin
                acc[pending] <= sum;
                cnt[pending] <= cnt[pending] + 1'b1;
            end
        end
    end
`else
    always_comb begin
        pub      = take;
        pub_data = adc_result;
    end
`endif

    // p0: publish register, one cycle after the adc_valid strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_valid <= 1'b0;
            smp_chan  <= 3'd0;
            smp_data  <= 12'd0;
        end else begin
            smp_valid <= pub;
            if (pub) begin
                smp_chan <= pending;
                smp_data <= pub_data;
            end
        end
    end

    assign rd_ok = int'(rd_chan) < NUM_CH;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            set_v[i] = smp_valid && (smp_chan == 3'(i));
            clr_v[i] = rd_en && rd_ok && (rd_chan == 3'(i));
        end
    end

    // p1: register file and flags commit during the smp_valid cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) regs[i] <= 12'd0;
            ch_fresh <= '0;
            ch_ovr   <= '0;
            rd_data  <= 12'd0;
        end else begin
            if (smp_valid) regs[smp_chan] <= smp_data;
            ch_fresh <= (ch_fresh & ~clr_v) | set_v;
            ch_ovr   <= (ch_ovr & ~clr_v) | (set_v & ch_fresh & ~clr_v);
            rd_data  <= rd_ok ? regs[rd_chan] : 12'd0;
        end
    end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Scenario bench for adc_channel_scheduler: expected samples are queued as results are driven
// and a monitor pops them on every smp_valid.
module tb_adc_channel_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [2:0]  adc_chan;
    logic [11:0] adc_result = 12'h000;
    logic        adc_valid = 1'b0;
    logic        smp_valid;
    logic [2:0]  smp_chan;
    logic [11:0] smp_data;
    logic [2:0]  rd_chan = 3'd0;
    logic        rd_en = 1'b0;
    logic [11:0] rd_data;
    logic [7:0]  ch_fresh;
    logic [7:0]  ch_ovr;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [14:0] exp_q [$];

    adc_channel_scheduler #(.NUM_CH(8), .AVG_LOG2(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .adc_chan(adc_chan), .adc_result(adc_result), .adc_valid(adc_valid),
        .smp_valid(smp_valid), .smp_chan(smp_chan), .smp_data(smp_data),
        .rd_chan(rd_chan), .rd_en(rd_en), .rd_data(rd_data),
        .ch_fresh(ch_fresh), .ch_ovr(ch_ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every published sample must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && smp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_sample: got chan=%0d data=%h, required no sample", smp_chan, smp_data);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if ({smp_chan, smp_data} !== e) begin
                    n_bad++;
                    $display("FAIL sample: got chan=%0d data=%h, required chan=%0d data=%h",
                             smp_chan, smp_data, e[14:12], e[11:0]);
                end
            end
        end
    end

    task automatic adc_pulse(input logic [11:0] d);
        repeat (30) @(posedge clk);
        #1 adc_result = d; adc_valid = 1'b1;
        @(posedge clk);
        #1 adc_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; ch_mask = 8'h00; rd_en = 1'b0; rd_chan = 3'd0; adc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({adc_chan, smp_valid, smp_chan, smp_data, rd_data, ch_fresh, ch_ovr, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got chan=%0d sv=%b sc=%0d sd=%h rd=%h fr=%h ov=%h busy=%b, required all 0",
                     adc_chan, smp_valid, smp_chan, smp_data, rd_data, ch_fresh, ch_ovr, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] res [5] = '{12'h100, 12'h111, 12'h222, 12'h333, 12'h444};
        logic [2:0]  sel [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        logic [2:0]  tag [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0};
        do_reset();
        ch_mask = 8'h07; enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (adc_chan !== sel[i]) begin
                n_bad++;
                $display("FAIL rr_adc_chan[%0d]: got %0d, required %0d", i, adc_chan, sel[i]);
            end
            if (i > 0) exp_q.push_back({tag[i], res[i]});
            adc_pulse(res[i]);
        end
        repeat (4) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rr_drained: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap_and_mask();
        logic [2:0] sel [5] = '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
        do_reset();
        ch_mask = 8'h81; enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (adc_chan !== sel[i]) begin
                n_bad++;
                $display("FAIL wrap_adc_chan[%0d]: got %0d, required %0d", i, adc_chan, sel[i]);
            end
            case (i)
                1: exp_q.push_back({3'd0, 12'hA01});
                2: begin ch_mask = 8'h01; exp_q.push_back({3'd7, 12'hA02}); end
                3: exp_q.push_back({3'd0, 12'hA03});
                4: exp_q.push_back({3'd0, 12'hA04});
                default: ;
            endcase
            adc_pulse(12'hA00 + 12'(i));
        end
        repeat (4) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_drained: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_flags();
        do_reset();
        ch_mask = 8'h08; enable = 1'b1;
        adc_pulse(12'h000);
        exp_q.push_back({3'd3, 12'h0AB});
        adc_pulse(12'h0AB);
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if (ch_fresh !== 8'h08 || ch_ovr !== 8'h00) begin
            n_bad++;
            $display("FAIL flags_first: got fresh=%h ovr=%h, required fresh=08 ovr=00", ch_fresh, ch_ovr);
        end
        exp_q.push_back({3'd3, 12'h0CD});
        adc_pulse(12'h0CD);
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if (ch_fresh !== 8'h08 || ch_ovr !== 8'h08) begin
            n_bad++;
            $display("FAIL flags_overrun: got fresh=%h ovr=%h, required fresh=08 ovr=08", ch_fresh, ch_ovr);
        end
        rd_chan = 3'd3; rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        n_cmp++;
        if (ch_fresh !== 8'h00 || ch_ovr !== 8'h00 || rd_data !== 12'h0CD) begin
            n_bad++;
            $display("FAIL flags_read: got fresh=%h ovr=%h rd=%h, required fresh=00 ovr=00 rd=0cd",
                     ch_fresh, ch_ovr, rd_data);
        end
        rd_chan = 3'd5;
        @(posedge clk); #1;
        n_cmp++;
        if (rd_data !== 12'h000) begin
            n_bad++;
            $display("FAIL rd_empty_chan: got %h, required 000", rd_data);
        end
        // Read acknowledge lands in the same cycle as the register-file write.
        rd_chan = 3'd3;
        exp_q.push_back({3'd3, 12'h0EF});
        adc_pulse(12'h0EF);
        rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        n_cmp++;
        if (ch_fresh !== 8'h08 || ch_ovr !== 8'h00 || rd_data !== 12'h0CD) begin
            n_bad++;
            $display("FAIL flags_set_clr: got fresh=%h ovr=%h rd=%h, required fresh=08 ovr=00 rd=0cd",
                     ch_fresh, ch_ovr, rd_data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rd_data !== 12'h0EF) begin
            n_bad++;
            $display("FAIL rd_new_value: got %h, required 0ef", rd_data);
        end
    endtask

    task automatic test_drain();
        do_reset();
        ch_mask = 8'h07; enable = 1'b1;
        adc_pulse(12'h000);
        exp_q.push_back({3'd0, 12'h5A0});
        adc_pulse(12'h5A0);
        #1 enable = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_busy: got %b, required 1", busy);
        end
        exp_q.push_back({3'd1, 12'h5A1});
        adc_pulse(12'h5A1);
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || adc_chan !== 3'd2) begin
            n_bad++;
            $display("FAIL drain_idle: got busy=%b adc_chan=%0d, required busy=0 adc_chan=2", busy, adc_chan);
        end
        adc_pulse(12'h5A2);
        adc_pulse(12'h5A3);
        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_drained: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        ch_mask = 8'h07; enable = 1'b1;
        adc_pulse(12'h000);
        exp_q.push_back({3'd0, 12'h7A0});
        adc_pulse(12'h7A0);
        exp_q.push_back({3'd1, 12'h7A1});
        adc_pulse(12'h7A1);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (ch_fresh !== 8'h03) begin
            n_bad++;
            $display("FAIL pre_reset_fresh: got %h, required 03", ch_fresh);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({adc_chan, smp_valid, smp_chan, smp_data, rd_data, ch_fresh, ch_ovr, busy} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got chan=%0d sv=%b sc=%0d sd=%h rd=%h fr=%h ov=%h busy=%b, required all 0",
                     adc_chan, smp_valid, smp_chan, smp_data, rd_data, ch_fresh, ch_ovr, busy);
        end
        @(posedge clk); #1 reset = 1'b0;
        adc_pulse(12'h7B0);
        exp_q.push_back({3'd0, 12'h7B1});
        adc_pulse(12'h7B1);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL post_reset_drained: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_avg();
        do_reset();
        ch_mask = 8'h01; enable = 1'b1;
        adc_pulse(12'd0);
        adc_pulse(12'd10);
        adc_pulse(12'd20);
        adc_pulse(12'd30);
        exp_q.push_back({3'd0, 12'd25});
        adc_pulse(12'd41);
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0 || ch_fresh !== 8'h01) begin
            n_bad++;
            $display("FAIL avg_publish: got %0d outstanding fresh=%h, required 0 outstanding fresh=01",
                     exp_q.size(), ch_fresh);
        end
    endtask

    initial begin
        test_reset();
`ifdef ADC_SCHED_AVG_EN
        test_avg();
`else
        test_round_robin();
        test_wrap_and_mask();
        test_flags();
        test_drain();
        test_reset_mid_frame();
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_channel_scheduler.md
Name: adc_channel_scheduler

Overview:
- Round-robin channel sequencer for the LTC2308 ADC interface block.
- Drives that block's 3-bit channel select and consumes its result/data_valid pair.
- Tags each returned 12-bit conversion with the channel it belongs to; the ADC is one frame pipelined, so the result in frame N belongs to the config sent in frame N-1.
- Publishes a tagged sample stream and keeps a per-channel latest-value register file with fresh/overrun flags for downstream vocoder filter banks.

Parameters:
NUM_CH, 8, number of ADC channels scheduled (channel ids 0..NUM_CH-1, max 8)
AVG_LOG2, 2, log2 of samples averaged per channel when ADC_SCHED_AVG_EN is defined

Ports:
clk  in  1  system clock, same clock as the ADC interface
reset  in  1  asynchronous, active-high reset
enable  in  1  run scheduling when 1
ch_mask  in  NUM_CH  channel enable mask, bit i = channel i
adc_chan  out  3  channel select to the ADC interface
adc_result  in  12  conversion result from the ADC interface
adc_valid  in  1  one-cycle result strobe from the ADC interface
smp_valid  out  1  one-cycle published-sample strobe
smp_chan  out  3  channel id of the published sample
smp_data  out  12  published sample value
rd_chan  in  3  register-file read address
rd_en  in  1  read acknowledge; clears fresh/ovr for rd_chan
rd_data  out  12  latest value of rd_chan, registered
ch_fresh  out  NUM_CH  bit i = unread sample available for channel i
ch_ovr  out  NUM_CH  sticky; sample on channel i overwritten while unread
busy  out  1  1 when state is not IDLE

Behaviour:
- Reset: state IDLE. adc_chan=0, pending=0, smp_valid=0, smp_chan=0, smp_data=0, rd_data=0, ch_fresh=0, ch_ovr=0, busy=0. Register file cleared to 0.
- next(c, m): first set bit of m strictly after c, searched modulo NUM_CH with wrap (NUM_CH-1 wraps to 0). If c is the only set bit, next returns c.
- IDLE:
  - Ignores adc_valid.
  - When enable=1 and ch_mask≠0: adc_chan <= lowest set bit of ch_mask, then go to PRIME.
- PRIME:
  - On adc_valid, discard adc_result because it is stale.
  - pending <= adc_chan; adc_chan <= next(adc_chan, ch_mask); go to RUN.
  - If enable=0 or ch_mask=0 before adc_valid, return to IDLE.
- RUN, on each adc_valid:
  - Publish adc_result tagged with pending.
  - pending <= adc_chan; adc_chan <= next(adc_chan, ch_mask).
  - ch_mask is sampled in the adc_valid cycle. A pending channel that has since been masked is still published.
- RUN to DRAIN: when enable=0 or ch_mask=0 with no adc_valid in the same cycle. If both occur in the same cycle, publish first, then go to DRAIN.
- DRAIN: on the next adc_valid, publish the result tagged with pending, then go to IDLE. adc_chan holds its value.
- Publish timing:
  - smp_valid pulses 1 cycle exactly, in the cycle after adc_valid, with smp_chan/smp_data valid that cycle.
  - reg[pending] is written in the same cycle.
  - smp_chan/smp_data hold their value between pulses.
- adc_chan changes only in the cycle after adc_valid and stays stable for the whole next config window.
- Flags per channel i, with set = publish to i and clr = (rd_en & rd_chan==i):
  - fresh <= (fresh & ~clr) | set.
  - ovr <= (ovr & ~clr) | (set & fresh & ~clr).
  - Simultaneous set and clr leaves fresh=1 and does not set ovr.
- rd_data <= reg[rd_chan] every cycle (1-cycle latency). A same-cycle write returns the old value.
- rd_chan ≥ NUM_CH: rd_data=0 and rd_en has no effect.
- Reset asserted mid-frame: immediately return to the reset state. The first post-reset result is handled by PRIME.

Optional Feature:
ADC_SCHED_AVG_EN
- Defined:
  - Each channel has a (12+AVG_LOG2)-bit accumulator and an AVG_LOG2-bit counter.
  - Each RUN/DRAIN result adds into the pending channel's accumulator.
  - On the 2^AVG_LOG2-th sample, publish acc>>AVG_LOG2 (truncated), then clear the accumulator and counter.
  - The flags/register file update only on publish.
  - All accumulators and counters clear on the IDLE→PRIME transition.
  - DRAIN discards a partial accumulation and publishes nothing.
- Undefined: every result is published directly; AVG_LOG2 is unused.

Test Plan:
1. ch_mask=8'h07, enable=1, adc_valid every 32 cycles with results 0x100,0x111,0x222,0x333,0x444 → first result discarded; smp_chan sequence 0,1,2,0 with data 0x111,0x222,0x333,0x444; adc_chan sequence 0,1,2,0,1.
2. ch_mask=8'h81 → adc_chan alternates 0,7,0 (wrap); change mask to 8'h01 mid-RUN → pending 7 still published, then only channel 0 published.
3. Channel 3 published twice without rd_en → ch_fresh[3]=1, ch_ovr[3]=1; rd_chan=3, rd_en=1 → both cleared, rd_data=second value the next cycle.
4. Drop enable in RUN → exactly one more smp_valid on the next adc_valid, then busy=0; later adc_valid pulses produce no smp_valid.
5. Assert reset mid-frame during RUN with fresh flags set → all outputs 0 immediately; re-enable → PRIME discards the first result.
6. ADC_SCHED_AVG_EN, AVG_LOG2=2, ch_mask=8'h01, results 10,20,30,41 after prime → single smp_data=25 after the 4th result.
